// File: rtl/square_16_16.sv
// rtl/square_16_16.sv - unsigned 16.16 fixed-point squarer, iterative shift-add
// Retires BITS_PER_CYCLE multiplier bits per BUSY cycle; saturates to all-ones on overflow.
module square_16_16 #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
);

  localparam int         N      = 32 / BITS_PER_CYCLE;
  localparam logic [5:0] N_LOAD = 6'(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] y_q, y_d;
  logic        ovf_q, ovf_d;
  logic [63:0] step_sum;

  // One iteration: add the shifted multiplicand for each of the low multiplier bits.
  always_comb begin
    step_sum = acc_q;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier_q[k]) begin
        step_sum = step_sum + (mcand_q << k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = {32'd0, x};
          mplier_d = x;
          acc_d    = 64'd0;
          cnt_d    = N_LOAD;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d = S_DONE;
          // Result is latched here so y/ovf stay frozen for the whole DONE hold.
          if (step_sum[63:48] != 16'd0) begin
            y_d   = 32'hFFFF_FFFF;
            ovf_d = 1'b1;
          end else begin
            y_d   = step_sum[47:16];
            ovf_d = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 6'd0;
      y_q      <= 32'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_square_16_16.sv
// tb/tb_square_16_16.sv - scoreboard bench for square_16_16
// Stimulus pushes expected results; a negedge monitor pops and compares on each delivery.
module tb_square_16_16;

  parameter int BPC = 1;
  localparam int N = 32 / BPC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] y;
  logic        ovf;

  square_16_16 #(.BITS_PER_CYCLE(BPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] y;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   acc_times[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;
  exp_t mon_e;
  int   mon_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t ref_sq(input logic [31:0] xv);
    logic [63:0] p;
    exp_t e;
    p = {32'd0, xv} * {32'd0, xv};
    if (p[63:48] != 16'd0) e = {32'hFFFF_FFFF, 1'b1};
    else                   e = {p[47:16], 1'b0};
    return e;
  endfunction

  // Monitor: latency on the rising edge of out_valid, data on each handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) acc_times.push_back(cyc);
      if (out_valid && !prev_valid) begin
        if (acc_times.size() == 0) check("latency_no_accept", 64'd1, 64'd0);
        else begin
          mon_c = acc_times.pop_front();
          check("latency_edges", 64'(cyc - mon_c), 64'(N + 1));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("y", 64'(y), 64'(mon_e.y));
          check("ovf", 64'(ovf), 64'(mon_e.ovf));
        end
      end
    end
    prev_valid <= out_valid;
  end

  // Called at posedge+1; holds in_valid until the accepting edge, then scrambles x.
  task automatic send(input logic [31:0] xv, input logic [31:0] ey, input logic eo);
    int n;
    n = 0;
    exp_q.push_back({ey, eo});
    in_valid = 1'b1;
    x = xv;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("accept_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = $urandom;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("drain_timeout", 64'd1, 64'd0);
  endtask

  logic [31:0] dir_x [8] = '{32'h0000_8000, 32'h0000_FFFF, 32'h0000_B505, 32'h0001_0000,
                             32'h0100_0000, 32'h0000_0000, 32'h00FF_FFFF, 32'h0002_0000};
  logic [31:0] dir_y [8] = '{32'h0000_4000, 32'h0000_FFFE, 32'h0000_8000, 32'h0001_0000,
                             32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FE00, 32'h0004_0000};
  logic        dir_o [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] rx;
    exp_t e;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) send(dir_x[i], dir_y[i], dir_o[i]);
    wait_drain();

    // Backpressure: result must hold while in_valid/x churn.
    out_ready = 1'b0;
    send(32'h0000_8000, 32'h0000_4000, 1'b0);
    n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("stall_valid_timeout", 64'd1, 64'd0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      x = $urandom;
      @(posedge clk); #1;
      check("stall_y", 64'(y), 64'h0000_4000);
      check("stall_ovf", 64'(ovf), 64'd0);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    repeat (N + 4) @(posedge clk);
    #1;
    check("no_stray_capture", 64'(out_valid), 64'd0);

    // Reset mid-BUSY aborts the pending result.
    send(32'h0003_0000, 32'h0009_0000, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_y", 64'(y), 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    exp_q.delete();
    acc_times.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(32'h0000_8000, 32'h0000_4000, 1'b0);
    wait_drain();

    for (int i = 0; i < 200; i++) begin
      rx = $urandom;
      if (i % 3 == 0) rx = rx >> 8;
      else if (i % 3 == 1) rx = rx >> 16;
      e = ref_sq(rx);
      send(rx, e.y, e.ovf);
    end
    wait_drain();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
